// File: rtl/boot_copy_pkg.sv
// Shared definitions for the boot copy engine.
// Holds the FSM state encoding, the default ready timeout and small helpers.
// No logic; imported by boot_copy and boot_copy_timer.
package boot_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Cycles a request phase may wait for ready before the copy aborts.
  localparam int TIMEOUT_DEFAULT = 255;

  // Address step between consecutive 32-bit words.
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Counter width able to hold values 0..limit.
  function automatic int timer_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/boot_copy_timer.sv
// Per-phase cycle counter: flags the first cycle of a phase and the last allowed cycle.
// Latency: count is 0 in the cycle after i_restart, advances by one per running cycle.
// Backpressure: none; saturates at TIMEOUT-1 so it never wraps back into the first cycle.
module boot_copy_timer
  import boot_copy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_restart,
  input  logic i_run,
  output logic o_first,
  output logic o_expired
);

  // A timeout below one cycle makes no sense; treat it as one.
  localparam int LIMIT = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int W = timer_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  // Clear on every state change, otherwise count cycles spent in a request phase.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_restart) begin
      count_q <= '0;
    end else if (i_run && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_first   = (count_q == '0);
  assign o_expired = (count_q == LAST);

endmodule

// File: rtl/boot_copy.sv
// Boot copy engine: copies i_count 32-bit words ROM->RAM and accumulates a word checksum.
// Latency: 4 cycles per word with 1-cycle-ready memories (2 READ + 2 WRITE); count 0 -> done next cycle.
// Backpressure: each request held until its ready (ignored in a phase's first cycle); TIMEOUT cycles without ready -> ERROR.
module boot_copy
  import boot_copy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_src,
  input  logic [31:0] i_dst,
  input  logic [15:0] i_count,
  output logic        o_rom_request,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_rdata,
  input  logic        i_rom_ready,
  output logic        o_ram_request,
  output logic        o_ram_rw,
  output logic [31:0] o_ram_address,
  output logic [31:0] o_ram_wdata,
  input  logic        i_ram_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_checksum
);

  state_t state_q, state_d;

  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [15:0] remaining_q;
  logic [31:0] wdata_q;
  logic [31:0] checksum_q;

  logic load;
  logic capture;
  logic accept;
  logic phase_first;
  logic phase_expired;

  // The timer restarts on any state change, so its first cycle marks the
  // cycle in which a lagging ready from the previous phase must be ignored.
  boot_copy_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_restart (state_d != state_q),
    .i_run     (o_busy),
    .o_first   (phase_first),
    .o_expired (phase_expired)
  );

  // State register; reset aborts any copy in flight immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, request strobes and datapath enables.
  always_comb begin
    state_d       = state_q;
    o_rom_request = 1'b0;
    o_ram_request = 1'b0;
    o_ram_rw      = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_error       = 1'b0;
    load          = 1'b0;
    capture       = 1'b0;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = (i_count == 16'd0) ? ST_DONE : ST_READ;
        end
      end

      ST_READ: begin
        o_busy        = 1'b1;
        o_rom_request = 1'b1;
        if (!phase_first && i_rom_ready) begin
          capture = 1'b1;
          state_d = ST_WRITE;
        end else if (phase_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_WRITE: begin
        o_busy        = 1'b1;
        o_ram_request = 1'b1;
        o_ram_rw      = 1'b1;
        if (!phase_first && i_ram_ready) begin
          accept  = 1'b1;
          state_d = (remaining_q == 16'd1) ? ST_DONE : ST_READ;
        end else if (phase_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        o_error = 1'b1;
        // A fresh start relaunches the copy exactly as from IDLE.
        if (i_start) begin
          load    = 1'b1;
          state_d = (i_count == 16'd0) ? ST_DONE : ST_READ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand latch on start, read capture, and pointer/checksum advance on write accept.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      wdata_q     <= '0;
      checksum_q  <= '0;
    end else begin
      if (load) begin
        src_q       <= i_src;
        dst_q       <= i_dst;
        remaining_q <= i_count;
        checksum_q  <= '0;
      end else if (accept) begin
        src_q       <= src_q + WORD_BYTES;
        dst_q       <= dst_q + WORD_BYTES;
        remaining_q <= remaining_q - 16'd1;
        checksum_q  <= checksum_q + wdata_q;
      end
      if (capture) begin
        wdata_q <= i_rom_rdata;
      end
    end
  end

  assign o_rom_address = src_q;
  assign o_ram_address = dst_q;
  assign o_ram_wdata   = wdata_q;
  assign o_checksum    = checksum_q;

endmodule

// File: doc/boot_copy.md
BOOT_COPY -- requirements
Module: boot_copy

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waited for any ready before error.
REQ-002 SHALL have port i_clock  input  1  single system clock, rising-edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse launching a copy.
REQ-005 SHALL have ports i_src, i_dst  input  32 each  byte addresses of source (ROM) and destination (RAM); word-aligned.
REQ-006 SHALL have port i_count  input  16  number of 32-bit words to copy.
REQ-007 SHALL have ports o_rom_request  output  1; o_rom_address  output  32; i_rom_rdata  input  32; i_rom_ready  input  1: ROM read initiator.
REQ-008 SHALL have ports o_ram_request  output  1; o_ram_rw  output  1 (1=write); o_ram_address  output  32; o_ram_wdata  output  32; i_ram_ready  input  1: RAM write initiator.
REQ-009 SHALL have ports o_busy  output  1; o_done  output  1; o_error  output  1; o_checksum  output  32.

Function
REQ-010 SHALL implement states IDLE, READ, WRITE, DONE, ERROR.
REQ-011 IDLE: on i_start, latch i_src, i_dst, i_count, clear checksum; count 0 -> DONE next cycle, else -> READ.
REQ-012 i_start while not in IDLE SHALL be ignored; latched operands SHALL NOT change mid-copy.
REQ-013 READ: o_rom_request=1, o_rom_address=current src; i_rom_ready SHALL be ignored in the first cycle of the request phase.
REQ-014 READ: from the second cycle on, i_rom_ready=1 SHALL capture i_rom_rdata into the write-data register, drop o_rom_request the following cycle, -> WRITE.
REQ-015 WRITE: o_ram_request=1, o_ram_rw=1, o_ram_address=current dst, o_ram_wdata=captured word; i_ram_ready ignored in the first cycle of the phase.
REQ-016 WRITE accept: add word to checksum (mod 2^32), src+=4, dst+=4 (wrap mod 2^32), remaining-=1; remaining 0 -> DONE, else -> READ.
REQ-017 Each request phase SHALL be preceded by at least one cycle with that request low, so a lagging ready from the previous phase is never counted.
REQ-018 Timeout counter SHALL reset on entering READ/WRITE; if it reaches TIMEOUT without accepted ready -> ERROR.
REQ-019 DONE: o_done=1 for exactly one cycle, then IDLE; ERROR: o_error held 1, requests low, until next i_start (which restarts as REQ-011).
REQ-020 o_busy=1 in READ and WRITE only; o_checksum SHALL hold final sum until next accepted i_start.
REQ-021 Outside READ/WRITE both requests SHALL be 0; o_ram_rw SHALL be 0 when o_ram_request is 0.
REQ-022 Minimum per-word latency with 1-cycle-ready memories SHALL be 4 cycles (2 READ, 2 WRITE).

Reset
REQ-023 i_reset SHALL force IDLE asynchronously; all outputs 0, including o_checksum, addresses, counters.
REQ-024 Reset mid-copy SHALL abort immediately with requests low; no partial completion flagged.

Structure
REQ-025 State encoding and TIMEOUT default SHALL live in the shared Rv32H package/include.
REQ-026 No sub-module required; one optional sub-module boot_copy_timer (timeout counter) permitted.

Verification
REQ-027 Bench SHALL drive the ROM model with 1-cycle registered ready (ready = request delayed one clock) and a RAM model with configurable latency.
REQ-028 Copy src=0x0, dst=0x1000, count=4, ROM words 1,2,3,4 -> RAM 0x1000..0x100C = 1..4, o_checksum=10, o_done pulse once, 16 busy cycles.
REQ-029 count=0 -> no requests, o_done one cycle after start, o_checksum=0.
REQ-030 RAM ready never asserted, TIMEOUT=8 -> o_error=1 after 8 WRITE cycles, requests low, o_busy=0.
REQ-031 dst=0xFFFFFFFC, count=2 -> writes to 0xFFFFFFFC then 0x00000000.
REQ-032 i_reset asserted during WRITE of word 2 of 4 -> all outputs 0 same cycle; subsequent start completes normally; second i_start during busy ignored.
